// File: rtl/serial_pkg.sv
// Shared definitions for the serializer/deserializer pair.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } serial_state_e;

  localparam int unsigned SERIAL_WIDTH   = 8;
  localparam int unsigned SERIAL_GAP_MIN = 1;

endpackage

// File: rtl/parallel2serial_if.sv
// Parallel word handshake plus serial-line outputs of parallel2serial.
interface parallel2serial_if
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             serial_start;
  logic             d;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, serial_start, d, busy, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, serial_start, d, busy, frame_done
  );

endinterface

// File: rtl/p2s_hold_buf.sv
// Single-entry hold buffer; in_ready is the registered inverse of the next full flag.
module p2s_hold_buf
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             bypass,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic wr_en;
  logic full_nxt;

  // A bypassed transfer goes straight to the shifter and never occupies the slot.
  always_comb begin
    wr_en    = in_valid && in_ready && !bypass;
    full_nxt = (full && !drain) || wr_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full     <= 1'b0;
      in_ready <= 1'b0;
      data     <= '0;
    end else begin
      full     <= full_nxt;
      in_ready <= !full_nxt;
      if (wr_en) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/parallel2serial.sv
// LSB-first serializer with one-word hold buffer and an enforced inter-frame idle gap.
module parallel2serial #(
  parameter int unsigned WIDTH = serial_pkg::SERIAL_WIDTH,
  parameter int unsigned GAP   = serial_pkg::SERIAL_GAP_MIN
) (
  input  logic               clk,
  input  logic               reset,
  parallel2serial_if.slave   bus
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = $clog2(GAP + 1);

  localparam logic [1:0] ST_IDLE  = serial_pkg::IDLE;
  localparam logic [1:0] ST_SHIFT = serial_pkg::SHIFT;
  localparam logic [1:0] ST_GAP   = serial_pkg::GAP;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             take, bypass, drain, load, done_nxt;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  p2s_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .in_ready (bus.in_ready),
    .bypass   (bypass),
    .drain    (drain),
    .full     (hold_full),
    .data     (hold_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, shifter/counter updates and word-source selection.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    bypass      = 1'b0;
    drain       = 1'b0;
    done_nxt    = 1'b0;
    take        = bus.in_valid && bus.in_ready;

    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          drain = 1'b1;
        end else if (take) begin
          bypass = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift_nxt = shift_reg >> 1;
        if (bit_cnt == BIT_W'(WIDTH - 1)) begin
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GAP_W'(GAP - 1);
          done_nxt    = 1'b1;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end else if (hold_full) begin
          drain = 1'b1;
        end else if (take) begin
          bypass = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The held word always wins; a fresh word only bypasses when the slot is empty.
    load = drain || bypass;
    if (load) begin
      state_nxt   = ST_SHIFT;
      shift_nxt   = drain ? hold_data : bus.in_data;
      bit_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg        <= '0;
      bit_cnt          <= '0;
      gap_cnt          <= '0;
      bus.serial_start <= 1'b0;
      bus.d            <= 1'b0;
      bus.busy         <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      shift_reg        <= shift_nxt;
      bit_cnt          <= bit_cnt_nxt;
      gap_cnt          <= gap_cnt_nxt;
      bus.serial_start <= load;
      bus.d            <= (state_nxt == ST_SHIFT) && shift_nxt[0];
      bus.busy         <= (state_nxt != ST_IDLE);
      bus.frame_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_parallel2serial.sv
// Directed and randomized bench for parallel2serial (GAP=1 and GAP=3 instances).
module tb_parallel2serial;
  import serial_pkg::*;

  localparam int unsigned W = SERIAL_WIDTH;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  parallel2serial_if #(.WIDTH(W)) busa ();
  parallel2serial_if #(.WIDTH(W)) busb ();

  parallel2serial #(.WIDTH(W), .GAP(1)) dut_a (.clk(clk), .reset(reset), .bus(busa.slave));
  parallel2serial #(.WIDTH(W), .GAP(3)) dut_b (.clk(clk), .reset(reset), .bus(busb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference queues: accepted words with their accept cycle, and what the line carried.
  logic [7:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  int         acc_a[$], acc_b[$], st_a[$], st_b[$], fd_a[$], fd_b[$];

  // Downstream deserializer model: frames restart on serial_start, WIDTH bits LSB first.
  bit         col_a, col_b;
  int         cnt_a, cnt_b;
  logic [7:0] wa, wb;

  always @(negedge clk) begin
    if (!reset) begin
      col_a = 1'b0;
      col_b = 1'b0;
    end else begin
      if (busa.serial_start) begin col_a = 1'b1; cnt_a = 0; wa = '0; st_a.push_back(cyc); end
      if (busa.frame_done) fd_a.push_back(cyc);
      if (col_a) begin
        wa[cnt_a] = busa.d;
        cnt_a++;
        if (cnt_a == int'(W)) begin got_a.push_back(wa); col_a = 1'b0; end
      end
      if (busb.serial_start) begin col_b = 1'b1; cnt_b = 0; wb = '0; st_b.push_back(cyc); end
      if (busb.frame_done) fd_b.push_back(cyc);
      if (col_b) begin
        wb[cnt_b] = busb.d;
        cnt_b++;
        if (cnt_b == int'(W)) begin got_b.push_back(wb); col_b = 1'b0; end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic drv(input int sel, input logic v, input logic [7:0] w);
    if (sel == 0) begin busa.in_valid = v; busa.in_data = w; end
    else          begin busb.in_valid = v; busb.in_data = w; end
  endtask

  // Offer one word (called at a negedge); optionally scramble in_data while not ready.
  task automatic offer(input int sel, input logic [7:0] w, input bit scramble, output int waited);
    bit   done;
    logic rdy;
    done   = 1'b0;
    waited = 0;
    for (int i = 0; i < 300; i++) begin
      rdy = (sel == 0) ? busa.in_ready : busb.in_ready;
      drv(sel, 1'b1, (rdy || !scramble) ? w : 8'($urandom));
      if (rdy) begin
        if (sel == 0) begin exp_a.push_back(w); acc_a.push_back(cyc); end
        else          begin exp_b.push_back(w); acc_b.push_back(cyc); end
        @(negedge clk);
        done = 1'b1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    drv(sel, 1'b0, w);
    n_tests++;
    assert (done)
    else begin
      n_fail++;
      $error("FAIL offer_timeout: word %0h never accepted", w);
    end
  endtask

  task automatic wait_idle(input int sel);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sel == 0 ? (!busa.busy && busa.in_ready) : (!busb.busy && busb.in_ready)) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    assert (done)
    else begin
      n_fail++;
      $error("FAIL idle_timeout: instance %0d still busy", sel);
    end
  endtask

  task automatic clear_q();
    exp_a.delete(); acc_a.delete(); got_a.delete(); st_a.delete(); fd_a.delete();
    exp_b.delete(); acc_b.delete(); got_b.delete(); st_b.delete(); fd_b.delete();
  endtask

  // Frame k starts one cycle after its accept, but no sooner than WIDTH+GAP after frame k-1.
  task automatic check_frames(input int sel, input string tag);
    logic [7:0] e[$], g[$];
    int         a[$], s[$], f[$];
    int         gp, pred, n;
    if (sel == 0) begin e = exp_a; g = got_a; a = acc_a; s = st_a; f = fd_a; gp = 1; end
    else          begin e = exp_b; g = got_b; a = acc_b; s = st_b; f = fd_b; gp = 3; end
    chk({tag, "_nwords"}, 32'(g.size()), 32'(e.size()));
    chk({tag, "_nstarts"}, 32'(s.size()), 32'(e.size()));
    chk({tag, "_ndone"}, 32'(f.size()), 32'(e.size()));
    n = e.size();
    if (g.size() < n) n = g.size();
    if (s.size() < n) n = s.size();
    pred = 0;
    for (int k = 0; k < n; k++) begin
      pred = (k == 0) ? a[k] + 1 : ((a[k] + 1 > pred + int'(W) + gp) ? a[k] + 1 : pred + int'(W) + gp);
      chk({tag, "_word"}, 32'(g[k]), 32'(e[k]));
      chk({tag, "_start_cyc"}, 32'(s[k]), 32'(pred));
      if (k < f.size()) chk({tag, "_done_cyc"}, 32'(f[k]), 32'(s[k] + int'(W)));
    end
    clear_q();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    int         wt;
    int         per;

    // Reset with in_valid asserted: nothing moves.
    reset = 1'b0;
    busa.in_valid = 1'b1; busa.in_data = 8'hEE;
    busb.in_valid = 1'b0; busb.in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(busa.in_ready), 32'd0);
    chk("rst_start", 32'(busa.serial_start), 32'd0);
    chk("rst_d", 32'(busa.d), 32'd0);
    chk("rst_busy", 32'(busa.busy), 32'd0);
    chk("rst_done", 32'(busa.frame_done), 32'd0);
    reset = 1'b1;
    busa.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 32'(busa.in_ready), 32'd1);
    chk("rst_ready_after_b", 32'(busb.in_ready), 32'd1);
    chk("rst_no_xfer", 32'(busa.busy), 32'd0);

    // Single frame 0xA5, cycle-by-cycle.
    w = 8'hA5;
    offer(0, w, 1'b0, wt);
    chk("sf_start", 32'(busa.serial_start), 32'd1);
    chk("sf_busy", 32'(busa.busy), 32'd1);
    chk("sf_bit0", 32'(busa.d), 32'(w[0]));
    for (int i = 1; i < int'(W); i++) begin
      @(negedge clk);
      chk("sf_bit", 32'(busa.d), 32'(w[i]));
      chk("sf_start_low", 32'(busa.serial_start), 32'd0);
    end
    @(negedge clk);
    chk("sf_done", 32'(busa.frame_done), 32'd1);
    chk("sf_gap_d", 32'(busa.d), 32'd0);
    chk("sf_gap_busy", 32'(busa.busy), 32'd1);
    @(negedge clk);
    chk("sf_idle_busy", 32'(busa.busy), 32'd0);
    chk("sf_idle_done", 32'(busa.frame_done), 32'd0);
    wait_idle(0);
    check_frames(0, "single");

    // Back-to-back: 0x3C, 0xFF, 0x01.
    offer(0, 8'h3C, 1'b0, wt);
    offer(0, 8'hFF, 1'b0, wt);
    chk("b2b_ready_full", 32'(busa.in_ready), 32'd0);
    offer(0, 8'h01, 1'b0, wt);
    chk("b2b_wait", 32'(wt), 32'd8);
    chk("b2b_ready_full2", 32'(busa.in_ready), 32'd0);
    wait_idle(0);
    if (st_a.size() >= 3) begin
      chk("b2b_period0", 32'(st_a[1] - st_a[0]), 32'd9);
      chk("b2b_period1", 32'(st_a[2] - st_a[1]), 32'd9);
    end
    check_frames(0, "b2b");

    // Backpressure with in_data scrambled while in_ready is low.
    offer(0, 8'h12, 1'b0, wt);
    offer(0, 8'h34, 1'b0, wt);
    offer(0, 8'h56, 1'b1, wt);
    chk("bp_wait", 32'(wt), 32'd8);
    wait_idle(0);
    check_frames(0, "bp");

    // Reset after bit 3 of 0x5A, then 0x81 must go through intact.
    w = 8'h5A;
    offer(0, w, 1'b0, wt);
    repeat (3) @(negedge clk);
    chk("mr_bit3", 32'(busa.d), 32'(w[3]));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mr_d", 32'(busa.d), 32'd0);
    chk("mr_start", 32'(busa.serial_start), 32'd0);
    chk("mr_busy", 32'(busa.busy), 32'd0);
    chk("mr_ready", 32'(busa.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_q();
    offer(0, 8'h81, 1'b0, wt);
    wait_idle(0);
    check_frames(0, "mr");

    // GAP=3 instance: two queued words, period WIDTH+3.
    offer(1, 8'hC3, 1'b0, wt);
    offer(1, 8'h7E, 1'b0, wt);
    wait_idle(1);
    per = (st_b.size() >= 2) ? st_b[1] - st_b[0] : -1;
    chk("g3_period", 32'(per), 32'd11);
    check_frames(1, "g3");

    // Random words with random idle spacing and random scrambling.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      offer(0, 8'($urandom), 1'($urandom), wt);
    end
    wait_idle(0);
    check_frames(0, "rnd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
